// File: rtl/usb4_tc_noc_fifo_ctrl_8_37.sv
// Show-ahead FIFO controller sequencing an external 8x37 two-port RAM (sync write, async read).
// Optional high-water-mark tracker is enabled by defining USB4_TC_NOC_FIFO_CTRL_HWM_EN.
module usb4_tc_noc_fifo_ctrl_8_37 #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 37,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [AW:0]      count,
    output logic             ram_wen,
    output logic [AW-1:0]    ram_waddr,
    output logic [WIDTH-1:0] ram_wdata,
    output logic             ram_ren,
    output logic [AW-1:0]    ram_raddr,
    input  logic [WIDTH-1:0] ram_rdata,
    output logic [AW:0]      hwm,
    input  logic             hwm_clr
);

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push, pop;

    // Handshakes are gated by rst_n so nothing completes while reset is held.
    assign in_ready  = (count_q != FULL);
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready & ~flush & rst_n;
    assign pop       = out_valid & out_ready & ~flush & rst_n;

    assign ram_wen   = push;
    assign ram_waddr = wr_ptr_q;
    assign ram_wdata = in_data;
    assign ram_ren   = out_valid;
    assign ram_raddr = rd_ptr_q;
    assign out_data  = ram_rdata;
    assign count     = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

`ifdef USB4_TC_NOC_FIFO_CTRL_HWM_EN
    logic [AW:0] hwm_q, hwm_d;

    // Clear reloads with the post-edge occupancy; flush leaves the mark alone.
    always_comb begin
        hwm_d = hwm_q;
        if (hwm_clr)
            hwm_d = count_d;
        else if (count_d > hwm_q)
            hwm_d = count_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            hwm_q <= '0;
        else
            hwm_q <= hwm_d;
    end

    assign hwm = hwm_q;
`else
    logic unused_hwm_clr;
    assign unused_hwm_clr = hwm_clr;
    assign hwm = '0;
`endif

endmodule

// File: tb/tb_usb4_tc_noc_fifo_ctrl_8_37.sv
// Scoreboard bench for usb4_tc_noc_fifo_ctrl_8_37 with an attached RAM model and queue-based reference.
// Honours USB4_TC_NOC_FIFO_CTRL_HWM_EN the same way as the design.
module tb_usb4_tc_noc_fifo_ctrl_8_37;

    localparam int DEPTH = 8;
    localparam int WIDTH = 37;
    localparam int AW    = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [AW:0]      count;
    logic             ram_wen;
    logic [AW-1:0]    ram_waddr;
    logic [WIDTH-1:0] ram_wdata;
    logic             ram_ren;
    logic [AW-1:0]    ram_raddr;
    logic [WIDTH-1:0] ram_rdata;
    logic [AW:0]      hwm;
    logic             hwm_clr;

    int checks   = 0;
    int failures = 0;

    logic [WIDTH-1:0] expQ[$];
    int               wrIdx = 0;
    int               rdIdx = 0;
    int               hwmExp = 0;
    logic [WIDTH-1:0] mem[DEPTH];

    usb4_tc_noc_fifo_ctrl_8_37 dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count),
        .ram_wen(ram_wen), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
        .ram_ren(ram_ren), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata),
        .hwm(hwm), .hwm_clr(hwm_clr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (ram_wen) mem[ram_waddr] <= ram_wdata;
    assign ram_rdata = ram_ren ? mem[ram_raddr] : '1;

    task automatic checkOutput(input string name, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares outputs against the queue model mid-cycle, then advances the model.
    always @(negedge clk) begin
        int  sz;
        bit  expPush, expPop;
        sz = expQ.size();
        if (!rst_n) begin
            checkOutput("rst_count", count, 0);
            checkOutput("rst_in_ready", in_ready, 1);
            checkOutput("rst_out_valid", out_valid, 0);
            checkOutput("rst_ram_wen", ram_wen, 0);
            checkOutput("rst_ram_ren", ram_ren, 0);
            checkOutput("rst_waddr", ram_waddr, 0);
            checkOutput("rst_raddr", ram_raddr, 0);
            checkOutput("rst_hwm", hwm, 0);
            expQ.delete();
            wrIdx = 0;
            rdIdx = 0;
            hwmExp = 0;
        end else begin
            expPush = in_valid && (sz != DEPTH) && !flush;
            expPop  = out_ready && (sz != 0) && !flush;
            checkOutput("count", count, sz);
            checkOutput("in_ready", in_ready, sz != DEPTH);
            checkOutput("out_valid", out_valid, sz != 0);
            checkOutput("ram_ren", ram_ren, sz != 0);
            checkOutput("ram_wen", ram_wen, expPush);
            checkOutput("ram_waddr", ram_waddr, wrIdx);
            checkOutput("ram_raddr", ram_raddr, rdIdx);
            if (expPush) checkOutput("ram_wdata", ram_wdata, in_data);
            if (sz != 0) checkOutput("out_data", out_data, expQ[0]);
`ifdef USB4_TC_NOC_FIFO_CTRL_HWM_EN
            checkOutput("hwm", hwm, hwmExp);
`else
            checkOutput("hwm_off", hwm, 0);
`endif
            if (flush) begin
                expQ.delete();
                wrIdx = 0;
                rdIdx = 0;
            end else begin
                if (expPop) begin
                    void'(expQ.pop_front());
                    rdIdx = (rdIdx + 1) % DEPTH;
                end
                if (expPush) begin
                    expQ.push_back(in_data);
                    wrIdx = (wrIdx + 1) % DEPTH;
                end
            end
            if (hwm_clr) hwmExp = expQ.size();
            else if (expQ.size() > hwmExp) hwmExp = expQ.size();
        end
    end

    task automatic applyStimulus(input logic iv, input logic [WIDTH-1:0] d, input logic ordy,
                                 input logic fl, input logic clr);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        hwm_clr   = clr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [WIDTH-1:0] base;
        logic [WIDTH-1:0] seq;
        base = 37'h10_0000_0000;
        seq  = '0;
        rst_n = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0; hwm_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        repeat (3) applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);

        // Fill to full plus one refused word, then drain past empty.
        for (int i = 0; i < 9; i++) applyStimulus(1'b1, base + WIDTH'(i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Steady push+pop at occupancy 3 so both pointers wrap.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, seq, 1'b0, 1'b0, 1'b0);
            seq++;
        end
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, seq, 1'b1, 1'b0, 1'b0);
            seq++;
        end

        // Flush at occupancy 5 while both handshakes are offered.
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, seq, 1'b0, 1'b0, 1'b0);
            seq++;
        end
        applyStimulus(1'b1, seq, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);

        // High-water-mark sequence: push 6, pop 4, push 1, then clear at occupancy 3.
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, base + WIDTH'(100 + i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, base + WIDTH'(200), 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
        repeat (2) applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);

        // Randomised traffic with occasional flush, clear and a mid-run reset.
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                rst_n = 1'b0;
                applyStimulus(1'b1, WIDTH'({$urandom, $urandom}), 1'b1, 1'b0, 1'b0);
                applyStimulus(1'b1, WIDTH'({$urandom, $urandom}), 1'b1, 1'b0, 1'b0);
                rst_n = 1'b1;
            end
            applyStimulus($urandom_range(0, 9) < 6, WIDTH'({$urandom, $urandom}),
                          $urandom_range(0, 9) < 5, $urandom_range(0, 29) == 0,
                          $urandom_range(0, 19) == 0);
        end
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
